// File: rtl/multi_channel_rate_encoder.sv
// Multi-channel spike encoder: turns per-channel intensities into spike trains,
// either as a rate code (period shrinks with intensity, optional LFSR jitter)
// or as time-to-first-spike within a fixed 2^VAL_W-cycle window.
module multi_channel_rate_encoder #(
    parameter int CHANNELS  = 4,
    parameter int VAL_W     = 4,
    parameter int JITTER_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [CHANNELS*VAL_W-1:0] values,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       spikes,
    output logic                      window_start
);

    localparam logic [VAL_W-1:0] WIN_MAX = '1;

    logic [VAL_W-1:0]    val_q   [CHANNELS];
    logic [VAL_W-1:0]    val_d   [CHANNELS];
    logic [VAL_W-1:0]    cnt_q   [CHANNELS];
    logic [VAL_W-1:0]    cnt_d   [CHANNELS];
    logic [VAL_W-1:0]    span    [CHANNELS];
    logic [VAL_W-1:0]    limit   [CHANNELS];
    logic [CHANNELS-1:0] jit;
    logic [VAL_W-1:0]    win_q, win_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic                lfsr_fb;
    logic                mode_q, mode_d;
    logic                mode_chg;
    logic [CHANNELS-1:0] spikes_q, spikes_d;
    logic                ws_q, ws_d;

    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign mode_chg = (mode != mode_q);

    // Per-channel rate threshold; jitter is suppressed when the threshold is
    // already 0 so the max-intensity channel cannot underflow.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            span[c]  = WIN_MAX - val_q[c];
            jit[c]   = (JITTER_EN != 0) && !mode_q && (span[c] != '0) && lfsr_q[3'(c % 8)];
            limit[c] = span[c] - VAL_W'(jit[c]);
        end
    end

    // Next-state: mode change clears counters, enable advances, otherwise freeze.
    always_comb begin
        mode_d   = mode_q;
        win_d    = win_q;
        lfsr_d   = lfsr_q;
        spikes_d = '0;
        ws_d     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            val_d[c] = load ? values[c*VAL_W +: VAL_W] : val_q[c];
            cnt_d[c] = cnt_q[c];
        end
        if (enable) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
        if (mode_chg) begin
            mode_d = mode;
            win_d  = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_d[c] = '0;
            end
        end else if (enable) begin
            win_d = win_q + 1'b1;
            ws_d  = (win_q == '0);
            for (int c = 0; c < CHANNELS; c++) begin
                if (val_q[c] == '0) begin
                    cnt_d[c] = '0;
                end else if (mode_q) begin
                    cnt_d[c]    = '0;
                    spikes_d[c] = (win_q == span[c]);
                end else if (cnt_q[c] >= limit[c]) begin
                    // >= rather than == so a freshly lowered limit fires at once
                    spikes_d[c] = 1'b1;
                    cnt_d[c]    = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= 1'b0;
            win_q    <= '0;
            lfsr_q   <= 8'h01;
            spikes_q <= '0;
            ws_q     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                val_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            mode_q   <= mode_d;
            win_q    <= win_d;
            lfsr_q   <= lfsr_d;
            spikes_q <= spikes_d;
            ws_q     <= ws_d;
            for (int c = 0; c < CHANNELS; c++) begin
                val_q[c] <= val_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign spikes       = spikes_q;
    assign window_start = ws_q;

endmodule

// File: tb/tb_multi_channel_rate_encoder.sv
// Bench for multi_channel_rate_encoder: a deterministic and a jittered instance
// share stimulus; both are compared every cycle against a behavioural model,
// plus a vector table and hand-written corner sequences.
module tb_multi_channel_rate_encoder;

    localparam int CH = 4;
    localparam int VW = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic          mode = 1'b0;
    logic [15:0]   values = '0;
    logic [CH-1:0] spk_det, spk_jit;
    logic          ws_det, ws_jit;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_channel_rate_encoder #(.CHANNELS(CH), .VAL_W(VW), .JITTER_EN(0)) dut_det (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .values(values),
        .mode(mode), .spikes(spk_det), .window_start(ws_det));

    multi_channel_rate_encoder #(.CHANNELS(CH), .VAL_W(VW), .JITTER_EN(1)) dut_jit (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .values(values),
        .mode(mode), .spikes(spk_jit), .window_start(ws_jit));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_val [CH];
    int            m_el  [2][CH];   // enabled cycles since last spike / clear
    int            m_tick;          // enabled cycles since last clear
    int            m_lfsr;
    bit            m_mode;
    logic [CH-1:0] m_spk [2];
    logic          m_ws;

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    always @(posedge clk) begin
        int period, j, phase;
        if (reset) begin
            m_lfsr = 1; m_mode = 1'b0; m_tick = 0; m_ws = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_spk[i] = '0;
                for (int c = 0; c < CH; c++) m_el[i][c] = 0;
            end
            for (int c = 0; c < CH; c++) m_val[c] = 0;
        end else begin
            if (mode != m_mode) begin
                m_mode = mode; m_tick = 0; m_ws = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    m_spk[i] = '0;
                    for (int c = 0; c < CH; c++) m_el[i][c] = 0;
                end
            end else if (enable) begin
                phase = m_tick % W;
                m_ws  = (phase == 0);
                for (int i = 0; i < 2; i++) begin
                    for (int c = 0; c < CH; c++) begin
                        period = W - m_val[c];
                        if (m_val[c] == 0) begin
                            m_spk[i][c] = 1'b0; m_el[i][c] = 0;
                        end else if (m_mode) begin
                            m_spk[i][c] = (phase == W - 1 - m_val[c]); m_el[i][c] = 0;
                        end else begin
                            j = (i == 1 && period > 1) ? ((m_lfsr >> (c % 8)) & 1) : 0;
                            if (m_el[i][c] + 1 >= period - j) begin
                                m_spk[i][c] = 1'b1; m_el[i][c] = 0;
                            end else begin
                                m_spk[i][c] = 1'b0; m_el[i][c]++;
                            end
                        end
                    end
                end
                m_tick++;
            end else begin
                m_ws = 1'b0;
                for (int i = 0; i < 2; i++) m_spk[i] = '0;
            end
            if (enable) m_lfsr = lfsr_next(m_lfsr);
            if (load) for (int c = 0; c < CH; c++) m_val[c] = int'(values[c*VW +: VW]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_det_spikes", int'(spk_det), int'(m_spk[0]));
            chk("model_det_ws", int'(ws_det), int'(m_ws));
            chk("model_jit_spikes", int'(spk_jit), int'(m_spk[1]));
            chk("model_jit_ws", int'(ws_jit), int'(m_ws));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic e, input logic l, input logic m,
                        input logic [15:0] v);
        reset = r; enable = e; load = l; mode = m; values = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic          rst, en, ld, md;
        logic [15:0]   vals;
        logic [CH-1:0] exp_spk;
        logic          exp_ws;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int last_t, ivl, bad_ivl, n4, n5, k;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h000B, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0};

        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_en = 1'b1;

        // Rate period 5 for intensity 11, freeze in the middle.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].md, tbl[i].vals);
            chk($sformatf("tbl%0d_spikes", i), int'(spk_det), int'(tbl[i].exp_spk));
            chk($sformatf("tbl%0d_ws", i), int'(ws_det), int'(tbl[i].exp_ws));
        end

        // TTFS: ch0=15, ch1=8, ch2=1 -> window positions 0, 7, 14.
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h018F);
        chk("ttfs_switch_spikes", int'(spk_det), 0);
        for (int e = 1; e <= 32; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
            k = (e - 1) % W;
            chk($sformatf("ttfs_e%0d_spikes", e), int'(spk_det),
                (k == 0 ? 1 : 0) + (k == 7 ? 2 : 0) + (k == 14 ? 4 : 0));
            chk($sformatf("ttfs_e%0d_ws", e), int'(ws_det), (k == 0) ? 1 : 0);
        end

        // Max and zero intensity.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst_spikes", int'(spk_det), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000F);
        for (int e = 0; e < 20; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk("max_zero_spikes", int'(spk_det), 1);
        end

        // Jitter: intervals of 4 or 5, both present.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000B);
        last_t = -1; bad_ivl = 0; n4 = 0; n5 = 0;
        for (int e = 0; e < 1000; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            if (spk_jit[0]) begin
                if (last_t >= 0) begin
                    ivl = e - last_t;
                    if (ivl == 4) n4++;
                    else if (ivl == 5) n5++;
                    else bad_ivl++;
                end
                last_t = e;
            end
        end
        chk("jitter_bad_intervals", bad_ivl, 0);
        chk("jitter_seen_4", (n4 > 0) ? 1 : 0, 1);
        chk("jitter_seen_5", (n5 > 0) ? 1 : 0, 1);

        // Freeze keeps phase; load of a higher intensity recovers via >=.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000B);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int e = 0; e < 7; e++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            chk("freeze_spikes", int'(spk_det), 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("resume_e3", int'(spk_det), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("resume_e4", int'(spk_det), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("resume_e5_spike", int'(spk_det), 1);
        for (int e = 0; e < 3; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk("count_up_spikes", int'(spk_det), 0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000E);
        chk("load_high_spikes", int'(spk_det), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("lowered_limit_spike", int'(spk_det), 1);

        // Mode toggle mid-window, then reset mid-operation.
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("toggle_spikes", int'(spk_det), 0);
        chk("toggle_ws", int'(ws_det), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("toggle_win0_ws", int'(ws_det), 1);
        chk("toggle_win0_spikes", int'(spk_det), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("toggle_win1_spike", int'(spk_det), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        chk("midrst_spikes", int'(spk_det), 0);
        chk("midrst_ws", int'(ws_det), 0);
        for (int e = 0; e < 20; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk("after_rst_spikes", int'(spk_det), 0);
        end

        // Randomised traffic against the model.
        for (int e = 0; e < 3000; e++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0) ? ~mode : mode,
                 16'($urandom()));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_channel_rate_encoder.md
MULTI_CHANNEL_RATE_ENCODER -- requirements
Module: multi_channel_rate_encoder

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent encoder channels (1..16).
REQ-002 The block SHALL have parameter VAL_W, default 4, giving the intensity width per channel (2..8); WINDOW = 2^VAL_W.
REQ-003 The block SHALL have parameter JITTER_EN, default 1: 1 = LFSR jitter active in rate mode, 0 = deterministic.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port enable, input, 1: 1 = advance all counters and the LFSR; 0 = freeze.
REQ-007 Port load, input, 1: capture values into the per-channel intensity registers.
REQ-008 Port values, input, CHANNELS*VAL_W: channel c intensity at bits [c*VAL_W +: VAL_W].
REQ-009 Port mode, input, 1: 0 = rate coding; 1 = time-to-first-spike (TTFS) coding.
REQ-010 Port spikes, output, CHANNELS: registered one-cycle spike pulse per channel.
REQ-011 Port window_start, output, 1: registered one-cycle pulse marking window counter = 0.

Function
REQ-012 On a clock edge with load=1, val_q[c] SHALL take values[c]; load acts regardless of enable; the new value governs from the next edge.
REQ-013 The block SHALL contain an 8-bit Fibonacci LFSR: taps x^8+x^6+x^5+x^4+1; seed 8'h01; shift left, feedback into bit 0; advance only on enabled edges.
REQ-014 Channel c jitter bit j[c] SHALL be lfsr[c mod 8] when JITTER_EN=1 and mode=0, else 0.
REQ-015 The block SHALL contain a window counter win, VAL_W bits; it increments on every enabled edge and wraps WINDOW-1 -> 0 in both modes.
REQ-016 window_start SHALL be 1 for exactly the cycle after each enabled edge at which win == 0.
REQ-017 Each channel SHALL hold a VAL_W-bit counter cnt[c].
REQ-018 Rate mode: limit[c] = (WINDOW-1-val_q[c]) - j[c], but j[c] is forced to 0 when WINDOW-1-val_q[c] == 0.
REQ-019 Rate mode: on an enabled edge with cnt[c] >= limit[c], spikes[c] <= 1 and cnt[c] <= 0; otherwise spikes[c] <= 0 and cnt[c] <= cnt[c]+1.
REQ-020 Rate mode: the ">=" compare SHALL recover cleanly when a load lowers the limit below the current count.
REQ-021 Rate mode spike period SHALL be WINDOW-val_q[c] cycles, or one cycle shorter when jitter applies.
REQ-022 TTFS mode: on an enabled edge with win == WINDOW-1-val_q[c], spikes[c] <= 1; this gives exactly one spike per window, earlier for larger intensity; cnt is unused and held at 0.
REQ-023 In both modes, val_q[c] == 0 SHALL produce no spikes on channel c.
REQ-024 The mode input SHALL be registered into mode_q; on an edge where mode != mode_q, mode_q updates, all cnt[c] and win clear to 0, spikes <= 0 and window_start <= 0 (even if enable=0); the LFSR is unaffected.
REQ-025 On an edge with enable=0 and no mode change, spikes and window_start SHALL go to 0, and cnt, win and the LFSR SHALL hold.
REQ-026 spikes SHALL never be asserted for two consecutive cycles on a channel whose period exceeds 1.

Reset
REQ-027 While reset=1 at an edge, the block SHALL set spikes=0, window_start=0, cnt[c]=0, win=0, val_q[c]=0, lfsr=8'h01 and mode_q=0.
REQ-028 Reset SHALL take priority over load, enable and mode change; a reset mid-window discards partial counts.
REQ-029 After reset, outputs SHALL stay 0 until values are loaded and enable=1.

Verification
REQ-030 Rate period, deterministic: JITTER_EN=0, VAL_W=4, reset, load ch0=11 with enable=0, then enable=1 -> spikes[0] high after enabled edges 5, 10, 15, ... (period 5), other channels silent.
REQ-031 Max and zero intensity: JITTER_EN=0, ch0=15, ch1=0 -> spikes[0] high every cycle; spikes[1] never high.
REQ-032 TTFS: mode=1, ch0=15, ch1=8, ch2=1 -> per 16-cycle window, spikes at win 0, 7 and 14 respectively; window_start every 16 enabled cycles.
REQ-033 Jitter: JITTER_EN=1, ch0=11 over 1000 enabled cycles -> every inter-spike interval is 4 or 5 and both values occur; LFSR sequence period is 255.
REQ-034 Freeze and load: enable=0 for 7 cycles mid-period -> no spikes and phase preserved; then load a higher value while cnt exceeds the new limit -> spike on the next enabled edge (REQ-020).
REQ-035 Mode switch and reset: toggle mode mid-window -> next cycle all counters are 0 and no spike; assert reset for 1 cycle mid-operation -> all outputs are 0 and val_q is cleared.
